packet_copy_stage: RTL and testbench

Clocked packet-copy stage for the FP pipeline. It is the inverse of the elimination element: instead of dropping a packet, it re-issues the accepted packet `Cnt_in+1` times downstream. Upstream and downstream use four-phase Send/Ack handshakes. It sits between a copy-request source (for example the matching/firing logic) and the next pipeline stage.

---
 rtl/packet_copy_stage.sv | 98 +++++++++
 tb/tb_packet_copy_stage.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/packet_copy_stage.sv
// Packet copy stage: accepts one packet over a four-phase handshake and re-issues it
// Cnt_in+1 times downstream, tagging each copy with its sequence index.
module packet_copy_stage #(
    parameter int DW = 16,
    parameter int CW = 2
) (
    input  logic          CLK,
    input  logic          MR,
    input  logic          Send_in,
    input  logic [DW-1:0] Data_in,
    input  logic [CW-1:0] Cnt_in,
    output logic          Ack_out,
    output logic          Send_out,
    output logic [DW-1:0] Data_out,
    output logic [CW-1:0] Seq_out,
    input  logic          Ack_in,
    output logic          Busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IN_ACK  = 2'd1,
        OUT_REQ = 2'd2,
        OUT_REL = 2'd3
    } state_t;

    state_t        state;
    logic [DW-1:0] data_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] seq_q;
    logic          ack_q;
    logic          send_q;
    logic          busy_q;

    always_ff @(posedge CLK or negedge MR) begin
        if (!MR) begin
            state  <= IDLE;
            data_q <= '0;
            cnt_q  <= '0;
            seq_q  <= '0;
            ack_q  <= 1'b0;
            send_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Send_in) begin
                        data_q <= Data_in;
                        cnt_q  <= Cnt_in;
                        seq_q  <= '0;
                        ack_q  <= 1'b1;
                        busy_q <= 1'b1;
                        state  <= IN_ACK;
                    end
                end
                IN_ACK: begin
                    if (!Send_in) begin
                        ack_q  <= 1'b0;
                        send_q <= 1'b1;
                        state  <= OUT_REQ;
                    end
                end
                OUT_REQ: begin
                    if (Ack_in) begin
                        send_q <= 1'b0;
                        state  <= OUT_REL;
                    end
                end
                OUT_REL: begin
                    // Equality test rather than a wrap check lets the all-ones count emit 2^CW copies.
                    if (!Ack_in) begin
                        if (seq_q == cnt_q) begin
                            busy_q <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            seq_q  <= seq_q + 1'b1;
                            send_q <= 1'b1;
                            state  <= OUT_REQ;
                        end
                    end
                end
                default: begin
                    ack_q  <= 1'b0;
                    send_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign Ack_out  = ack_q;
    assign Send_out = send_q;
    assign Data_out = data_q;
    assign Seq_out  = seq_q;
    assign Busy     = busy_q;

endmodule

// File: tb/tb_packet_copy_stage.sv
// Directed bench for packet_copy_stage: upstream sender and downstream receiver
// driven on the falling edge, outputs sampled on the falling edge.
module tb_packet_copy_stage;

    localparam int DW = 16;
    localparam int CW = 2;

    logic          CLK;
    logic          MR;
    logic          Send_in;
    logic [DW-1:0] Data_in;
    logic [CW-1:0] Cnt_in;
    logic          Ack_out;
    logic          Send_out;
    logic [DW-1:0] Data_out;
    logic [CW-1:0] Seq_out;
    logic          Ack_in;
    logic          Busy;

    int n_checks = 0;
    int n_pass   = 0;

    packet_copy_stage #(.DW(DW), .CW(CW)) dut (
        .CLK      (CLK),
        .MR       (MR),
        .Send_in  (Send_in),
        .Data_in  (Data_in),
        .Cnt_in   (Cnt_in),
        .Ack_out  (Ack_out),
        .Send_out (Send_out),
        .Data_out (Data_out),
        .Seq_out  (Seq_out),
        .Ack_in   (Ack_in),
        .Busy     (Busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Present a packet and complete the upstream handshake; returns at a negedge.
    task automatic send(input logic [DW-1:0] d, input logic [CW-1:0] c);
        int w;
        Send_in = 1'b1;
        Data_in = d;
        Cnt_in  = c;
        w = 0;
        @(negedge CLK);
        while (!Ack_out && w < 50) begin
            @(negedge CLK);
            w++;
        end
        check("send_ack_out", {31'd0, Ack_out}, 32'd1);
        check("send_busy", {31'd0, Busy}, 32'd1);
        Send_in = 1'b0;
        Data_in = 16'hDEAD;
        Cnt_in  = 2'd1;
    endtask

    // Downstream receiver: acknowledges n copies, raising Ack_in rdly cycles after
    // Send_out and dropping it fdly cycles after Send_out falls.
    task automatic serve(input logic [DW-1:0] d, input int n, input int rdly, input int fdly);
        int w;
        int bad;
        for (int i = 0; i < n; i++) begin
            w = 0;
            while (!Send_out && w < 50) begin
                @(negedge CLK);
                w++;
            end
            check("copy_send_out", {31'd0, Send_out}, 32'd1);
            check("copy_data", {16'd0, Data_out}, {16'd0, d});
            check("copy_seq", {30'd0, Seq_out}, i);
            if (i > 0) check("copy_gap", w, 1);
            bad = 0;
            for (int k = 0; k < rdly; k++) begin
                @(negedge CLK);
                if (!Send_out || Data_out !== d || Seq_out !== i[CW-1:0]) bad++;
            end
            if (rdly > 0) check("req_hold", bad, 0);
            Ack_in = 1'b1;
            w = 0;
            @(negedge CLK);
            while (Send_out && w < 50) begin
                @(negedge CLK);
                w++;
            end
            check("rel_send_low", {31'd0, Send_out}, 32'd0);
            check("rel_seq", {30'd0, Seq_out}, i);
            bad = 0;
            for (int k = 0; k < fdly; k++) begin
                @(negedge CLK);
                if (Send_out || Data_out !== d) bad++;
            end
            if (fdly > 0) check("rel_hold", bad, 0);
            Ack_in = 1'b0;
        end
        @(negedge CLK);
    endtask

    task automatic expect_idle(input string tag, input int cycles);
        int rises;
        rises = 0;
        for (int k = 0; k < cycles; k++) begin
            if (Send_out || Busy) rises++;
            @(negedge CLK);
        end
        check(tag, rises, 0);
    endtask

    initial begin
        int bad;
        MR      = 1'b0;
        Send_in = 1'b1;
        Data_in = 16'h00AA;
        Cnt_in  = 2'd0;
        Ack_in  = 1'b1;

        // 1. reset held with inputs active
        bad = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            if (Ack_out || Send_out || Busy || Data_out !== 16'd0 || Seq_out !== 2'd0) bad++;
        end
        check("reset_outputs", bad, 0);
        check("reset_ack", {31'd0, Ack_out}, 32'd0);
        MR = 1'b1;
        @(negedge CLK);
        check("reset_release_ack", {31'd0, Ack_out}, 32'd1);
        check("reset_release_data", {16'd0, Data_out}, 32'h00AA);
        Ack_in = 1'b0;
        Send_in = 1'b0;
        serve(16'h00AA, 1, 0, 0);
        expect_idle("reset_pkt_done", 3);

        // 2. single emission
        send(16'h1234, 2'd0);
        serve(16'h1234, 1, 0, 0);
        check("single_busy", {31'd0, Busy}, 32'd0);
        expect_idle("single_quiet", 5);

        // 3. maximum copies, no wrap
        send(16'hBEEF, 2'd3);
        serve(16'hBEEF, 4, 0, 0);
        check("max_busy", {31'd0, Busy}, 32'd0);
        check("max_seq_nowrap", {30'd0, Seq_out}, 32'd3);
        expect_idle("max_quiet", 6);

        // 4. stalling receiver
        send(16'hA5C3, 2'd1);
        serve(16'hA5C3, 2, 5, 4);
        expect_idle("stall_quiet", 5);

        // 5. back-to-back: second packet waits for IDLE
        send(16'h0001, 2'd2);
        @(negedge CLK);
        Send_in = 1'b1;
        Data_in = 16'h0002;
        Cnt_in  = 2'd0;
        bad = 0;
        fork
            serve(16'h0001, 3, 0, 0);
            begin
                for (int k = 0; k < 100; k++) begin
                    if (!Busy) break;
                    if (Ack_out) bad++;
                    @(negedge CLK);
                end
            end
        join
        check("b2b_no_early_ack", bad, 0);
        send(16'h0002, 2'd0);
        serve(16'h0002, 1, 0, 0);
        expect_idle("b2b_quiet", 4);

        // 6. reset during copy 1 of 3
        send(16'h5555, 2'd2);
        serve(16'h5555, 1, 0, 0);
        check("mid_copy1_req", {31'd0, Send_out}, 32'd1);
        check("mid_copy1_seq", {30'd0, Seq_out}, 32'd1);
        #2 MR = 1'b0;
        #1;
        check("mid_rst_send", {31'd0, Send_out}, 32'd0);
        check("mid_rst_seq", {30'd0, Seq_out}, 32'd0);
        check("mid_rst_busy", {31'd0, Busy}, 32'd0);
        @(negedge CLK);
        @(negedge CLK);
        MR = 1'b1;
        expect_idle("mid_rst_quiet", 10);
        check("mid_rst_ack", {31'd0, Ack_out}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
